// File: rtl/nv_dw_lsd_norm_pipe_if.sv
// Handshake bundle for the leading-sign/leading-zero normaliser pipe.
// The master side drives operands and out_prdy; the slave side is the pipe.
interface nv_dw_lsd_norm_pipe_if #(
    parameter int A_WIDTH   = 16,
    parameter int ENC_WIDTH = $clog2(A_WIDTH + 1)
);
    logic                 in_pvld;
    logic                 in_prdy;
    logic [A_WIDTH-1:0]   in_data;
    logic                 in_mode;
    logic [ENC_WIDTH-1:0] in_max_shift;
    logic                 out_pvld;
    logic                 out_prdy;
    logic [ENC_WIDTH-1:0] out_enc;
    logic [A_WIDTH-1:0]   out_data;
    logic                 out_all_same;

    modport master (
        output in_pvld, in_data, in_mode, in_max_shift, out_prdy,
        input  in_prdy, out_pvld, out_enc, out_data, out_all_same
    );

    modport slave (
        input  in_pvld, in_data, in_mode, in_max_shift, out_prdy,
        output in_prdy, out_pvld, out_enc, out_data, out_all_same
    );
endinterface

// File: rtl/nv_dw_lsd_norm_pipe.sv
// Two-stage leading-sign/leading-zero counter with clamped normalising shift.
// Define NV_DW_LSD_NORM_SHIFT_EN to build the S2 barrel shifter.
module nv_dw_lsd_norm_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int ENC_WIDTH = $clog2(A_WIDTH + 1)
) (
    input logic                   nvdla_core_clk,
    input logic                   nvdla_core_rstn,
    nv_dw_lsd_norm_pipe_if.slave  bus
);
    logic                 s1_vld_q, s1_vld_d;
    logic [A_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic [ENC_WIDTH-1:0] s1_enc_q, s1_enc_d;
    logic                 s1_same_q, s1_same_d;
    logic                 s2_vld_q, s2_vld_d;
    logic [A_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic [ENC_WIDTH-1:0] s2_enc_q, s2_enc_d;
    logic                 s2_same_q, s2_same_d;
    logic                 s1_adv, s2_adv;
    logic [A_WIDTH-1:0]   det_vec;
    logic [ENC_WIDTH-1:0] lz;
    logic [A_WIDTH-1:0]   norm_data;
`ifdef NV_DW_LSD_NORM_SHIFT_EN
    logic [ENC_WIDTH-1:0] s1_max_q, s1_max_d;
    logic [ENC_WIDTH-1:0] shift;
`endif

    function automatic logic [ENC_WIDTH-1:0] lzc(input logic [A_WIDTH-1:0] v);
        lzc = ENC_WIDTH'(A_WIDTH);
        for (int i = 0; i < A_WIDTH; i++) begin
            if (v[i]) lzc = ENC_WIDTH'(A_WIDTH - 1 - i);
        end
    endfunction

    assign s2_adv      = !s2_vld_q || bus.out_prdy;
    assign s1_adv      = !s1_vld_q || (s2_adv && s1_vld_q);
    assign bus.in_prdy = s1_adv;

    // Sign mode folds the MSB away so both modes become a leading-zero count.
    assign det_vec = bus.in_mode ? bus.in_data
                   : bus.in_data ^ {A_WIDTH{bus.in_data[A_WIDTH-1]}};
    assign lz      = lzc(det_vec);

`ifdef NV_DW_LSD_NORM_SHIFT_EN
    assign shift     = (s1_enc_q < s1_max_q) ? s1_enc_q : s1_max_q;
    assign norm_data = s1_data_q << shift;
`else
    assign norm_data = s1_data_q;
`endif

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_data_d = s1_data_q;
        s1_enc_d  = s1_enc_q;
        s1_same_d = s1_same_q;
`ifdef NV_DW_LSD_NORM_SHIFT_EN
        s1_max_d  = s1_max_q;
`endif
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;
        s2_enc_d  = s2_enc_q;
        s2_same_d = s2_same_q;
        if (s1_adv) begin
            s1_vld_d = bus.in_pvld;
            if (bus.in_pvld) begin
                s1_data_d = bus.in_data;
                s1_enc_d  = bus.in_mode ? lz : lz - 1'b1;
                s1_same_d = ~|det_vec;
`ifdef NV_DW_LSD_NORM_SHIFT_EN
                s1_max_d  = bus.in_max_shift;
`endif
            end
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_data_d = norm_data;
                s2_enc_d  = s1_enc_q;
                s2_same_d = s1_same_q;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_enc_q  <= '0;
            s1_same_q <= 1'b0;
`ifdef NV_DW_LSD_NORM_SHIFT_EN
            s1_max_q  <= '0;
`endif
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_enc_q  <= '0;
            s2_same_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            s1_enc_q  <= s1_enc_d;
            s1_same_q <= s1_same_d;
`ifdef NV_DW_LSD_NORM_SHIFT_EN
            s1_max_q  <= s1_max_d;
`endif
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
            s2_enc_q  <= s2_enc_d;
            s2_same_q <= s2_same_d;
        end
    end

    assign bus.out_pvld     = s2_vld_q;
    assign bus.out_data     = s2_data_q;
    assign bus.out_enc      = s2_enc_q;
    assign bus.out_all_same = s2_same_q;
endmodule

// File: tb/tb_nv_dw_lsd_norm_pipe.sv
// Directed and streaming checks for nv_dw_lsd_norm_pipe at A_WIDTH=8.
// Expected out_data follows NV_DW_LSD_NORM_SHIFT_EN.
module tb_nv_dw_lsd_norm_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    nv_dw_lsd_norm_pipe_if #(.A_WIDTH(8)) bus();

    nv_dw_lsd_norm_pipe #(.A_WIDTH(8)) u_dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [7:0] d;
        logic [3:0] ms;
        logic [3:0] enc;
        logic [7:0] dsh;
        logic       as;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [7:0] d, input logic m,
                                  input logic [3:0] ms, output logic [3:0] enc,
                                  output logic [7:0] od, output logic as);
        int k;
        int sh;
        if (m) begin
            k = 7;
            while (k >= 0 && d[k] == 1'b0) k--;
            enc = 4'(7 - k);
            as  = (d == 8'h00);
        end else begin
            k = 6;
            while (k >= 0 && d[k] == d[7]) k--;
            enc = 4'(6 - k);
            as  = (enc == 4'd7);
        end
        sh = (int'(enc) < int'(ms)) ? int'(enc) : int'(ms);
`ifdef NV_DW_LSD_NORM_SHIFT_EN
        od = d << sh;
`else
        od = d;
        sh = 0;
`endif
    endfunction

    task automatic test_reset();
        bus.in_pvld = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0;
        bus.in_max_shift = '0; bus.out_prdy = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (bus.out_pvld !== 1'b0) begin
            n_err++; $display("FAIL reset_pvld got %b want 0", bus.out_pvld);
        end
        n_vec++;
        if (bus.in_prdy !== 1'b1) begin
            n_err++; $display("FAIL reset_prdy got %b want 1", bus.in_prdy);
        end
        n_vec++;
        if (bus.out_enc !== 4'd0 || bus.out_data !== 8'h00 || bus.out_all_same !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fields got enc=%0d data=%h as=%b want 0/00/0",
                     bus.out_enc, bus.out_data, bus.out_all_same);
        end
    endtask

    task automatic test_directed();
        vec_t tbl[9];
        logic [7:0] ed;
        tbl[0] = '{1'b0, 8'hE5, 4'd8,  4'd2, 8'h94, 1'b0};
        tbl[1] = '{1'b1, 8'h16, 4'd8,  4'd3, 8'hB0, 1'b0};
        tbl[2] = '{1'b1, 8'h00, 4'd8,  4'd8, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 8'hFF, 4'd8,  4'd7, 8'h80, 1'b1};
        tbl[4] = '{1'b1, 8'h05, 4'd1,  4'd5, 8'h0A, 1'b0};
        tbl[5] = '{1'b0, 8'h0F, 4'd0,  4'd3, 8'h0F, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 4'd15, 4'd7, 8'h00, 1'b1};
        tbl[7] = '{1'b1, 8'h80, 4'd15, 4'd0, 8'h80, 1'b0};
        tbl[8] = '{1'b0, 8'h40, 4'd15, 4'd0, 8'h40, 1'b0};
        bus.out_prdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
`ifdef NV_DW_LSD_NORM_SHIFT_EN
            ed = tbl[i].dsh;
`else
            ed = tbl[i].d;
`endif
            bus.in_pvld = 1'b1; bus.in_data = tbl[i].d;
            bus.in_mode = tbl[i].m; bus.in_max_shift = tbl[i].ms;
            tick();
            bus.in_pvld = 1'b0;
            n_vec++;
            if (bus.out_pvld !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_early_pvld got %b want 0", i, bus.out_pvld);
            end
            tick();
            n_vec++;
            if (bus.out_pvld !== 1'b1 || bus.out_enc !== tbl[i].enc ||
                bus.out_data !== ed || bus.out_all_same !== tbl[i].as) begin
                n_err++;
                $display("FAIL dir%0d got v=%b enc=%0d data=%h as=%b want 1/%0d/%h/%b",
                         i, bus.out_pvld, bus.out_enc, bus.out_data, bus.out_all_same,
                         tbl[i].enc, ed, tbl[i].as);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] vals[4];
        logic [7:0] got[4];
        int idx, acc, ng;
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h00;
        idx = 0; acc = 0; ng = 0;
        bus.in_mode = 1'b1; bus.in_max_shift = 4'd0; bus.out_prdy = 1'b0;
        bus.in_pvld = 1'b1; bus.in_data = vals[0];
        #1;
        for (int c = 0; c < 5; c++) begin
            if (bus.in_prdy) begin acc++; idx++; end
            tick();
            bus.in_data = vals[idx];
            #1;
            if (acc == 2) begin
                n_vec++;
                if (bus.out_pvld !== 1'b1 || bus.out_data !== 8'h01 || bus.out_enc !== 4'd7) begin
                    n_err++;
                    $display("FAIL bp_stall_hold got v=%b data=%h enc=%0d want 1/01/7",
                             bus.out_pvld, bus.out_data, bus.out_enc);
                end
            end
        end
        n_vec++;
        if (acc !== 2) begin
            n_err++; $display("FAIL bp_accepted got %0d want 2", acc);
        end
        n_vec++;
        if (bus.in_prdy !== 1'b0) begin
            n_err++; $display("FAIL bp_full_prdy got %b want 0", bus.in_prdy);
        end
        bus.out_prdy = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (bus.in_pvld && bus.in_prdy) idx++;
            if (bus.out_pvld && ng < 4) begin got[ng] = bus.out_data; ng++; end
            tick();
            bus.in_pvld = (idx < 3);
            bus.in_data = vals[idx < 3 ? idx : 3];
            #1;
        end
        n_vec++;
        if (ng !== 3) begin
            n_err++; $display("FAIL bp_count got %0d want 3", ng);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i < ng && got[i] !== vals[i]) begin
                n_err++; $display("FAIL bp_order%0d got %h want %h", i, got[i], vals[i]);
            end
        end
        bus.in_pvld = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic [3:0] qe[$];
        logic [7:0] qd[$];
        logic       qa[$];
        logic [3:0] enc, e_enc;
        logic [7:0] od, d, e_d;
        logic       as, m, e_as;
        logic [3:0] ms;
        bus.out_prdy = 1'b1;
        for (int c = 0; c < 102; c++) begin
            if (c < 100) begin
                d  = 8'($urandom_range(0, 255));
                m  = 1'($urandom_range(0, 1));
                ms = 4'($urandom_range(0, 15));
                if (c % 10 == 3) d = 8'h00;
                if (c % 10 == 7) d = 8'hFF;
                model(d, m, ms, enc, od, as);
                qe.push_back(enc); qd.push_back(od); qa.push_back(as);
                bus.in_pvld = 1'b1; bus.in_data = d;
                bus.in_mode = m; bus.in_max_shift = ms;
            end else begin
                bus.in_pvld = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 100) begin
                e_enc = qe.pop_front(); e_d = qd.pop_front(); e_as = qa.pop_front();
                n_vec++;
                if (bus.out_pvld !== 1'b1 || bus.out_enc !== e_enc ||
                    bus.out_data !== e_d || bus.out_all_same !== e_as) begin
                    n_err++;
                    $display("FAIL stream%0d got v=%b enc=%0d data=%h as=%b want 1/%0d/%h/%b",
                             c - 1, bus.out_pvld, bus.out_enc, bus.out_data,
                             bus.out_all_same, e_enc, e_d, e_as);
                end
            end else begin
                n_vec++;
                if (bus.out_pvld !== 1'b0) begin
                    n_err++; $display("FAIL stream_edge%0d pvld got %b want 0", c, bus.out_pvld);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        bus.out_prdy = 1'b0; bus.in_mode = 1'b1; bus.in_max_shift = 4'd0;
        bus.in_pvld = 1'b1; bus.in_data = 8'h11;
        tick();
        bus.in_data = 8'h22;
        tick();
        bus.in_pvld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_pvld !== 1'b0 || bus.out_data !== 8'h00 ||
            bus.out_enc !== 4'd0 || bus.out_all_same !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async got v=%b data=%h enc=%0d as=%b want 0/00/0/0",
                     bus.out_pvld, bus.out_data, bus.out_enc, bus.out_all_same);
        end
        tick();
        rst_n = 1'b1;
        bus.out_prdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (bus.out_pvld !== 1'b0) begin
                n_err++; $display("FAIL rst_stale%0d pvld got %b want 0", c, bus.out_pvld);
            end
        end
        bus.in_pvld = 1'b1; bus.in_data = 8'hE5;
        bus.in_mode = 1'b0; bus.in_max_shift = 4'd8;
        tick();
        bus.in_pvld = 1'b0;
        tick();
        n_vec++;
`ifdef NV_DW_LSD_NORM_SHIFT_EN
        if (bus.out_pvld !== 1'b1 || bus.out_enc !== 4'd2 || bus.out_data !== 8'h94) begin
`else
        if (bus.out_pvld !== 1'b1 || bus.out_enc !== 4'd2 || bus.out_data !== 8'hE5) begin
`endif
            n_err++;
            $display("FAIL rst_next got v=%b enc=%0d data=%h", bus.out_pvld,
                     bus.out_enc, bus.out_data);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_streaming();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nv_dw_lsd_norm_pipe.md
# nv_dw_lsd_norm_pipe

Pipelined, parametrised leading-sign/leading-zero detector with normalising left shift, for the CDP/SDP floating-point conversion and normalisation paths. It accepts one operand per cycle on a valid/ready interface and returns the redundant-bit count, the normalised operand and an all-same flag two cycles later. It extends the combinational sign-bit detector with a leading-zero mode, a shift clamp, full backpressure and an optional normaliser.

## Interface
- A_WIDTH, 16: operand width, 2..128.
- ENC_WIDTH, $clog2(A_WIDTH+1): count width; it must represent A_WIDTH.
- nvdla_core_clk  in  1  core clock; all state on rising edge.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- in_pvld  in  1  input valid.
- in_prdy  out  1  input ready.
- in_data  in  A_WIDTH  operand.
- in_mode  in  1  0 = leading-sign (signed), 1 = leading-zero (unsigned).
- in_max_shift  in  ENC_WIDTH  upper limit on the normalising shift.
- out_pvld  out  1  output valid.
- out_prdy  in  1  output ready.
- out_enc  out  ENC_WIDTH  unclamped count.
- out_data  out  A_WIDTH  normalised operand.
- out_all_same  out  1  operand had no transition: all bits equal in mode 0, all zero in mode 1.

## Operation
- Count, mode 0: the number of bits below the MSB that equal the MSB, before the first differing bit. Range 0..A_WIDTH-1. An all-equal operand gives A_WIDTH-1.
- Count, mode 1: the number of leading zeros. Range 0..A_WIDTH. An all-zero operand gives A_WIDTH.
- shift = min(out_enc, in_max_shift). out_data = in_data << shift, zero-filled and truncated to A_WIDTH.
- Stage S1 (accept edge) registers the operand, mode, max_shift, count and all_same flag.
- Stage S2 registers shift, out_data, out_enc and out_all_same, then presents them.
- Each stage has a valid bit and advances when it is empty or downstream is taking its data:
  - s2_adv = !s2_vld | out_prdy.
  - s1_adv = !s1_vld | (s2_adv & s1_vld).
  - in_prdy = s1_adv.
- No bubbles are inserted. Throughput is 1 per cycle while out_prdy=1.
- Ordering is strictly FIFO. Data is never dropped or duplicated.
- Output fields hold stable while out_pvld=1 and out_prdy=0.
- Mode and max_shift travel with their operand, so a mode change between consecutive beats takes effect per beat.

## Timing
- Reset: out_pvld=0, in_prdy=1 after reset release, out_enc=0, out_data=0, out_all_same=0, both stage valids 0.
- Latency: a beat accepted at edge N appears with out_pvld=1 after edge N+1. It is consumed at the first edge where out_prdy=1.
- in_prdy is combinational from out_prdy and the stage valids. No combinational path exists from in_data to any output.
- Full (both stages valid, out_prdy=0): in_prdy=0. A simultaneous accept and drain while full is allowed when out_prdy=1.
- Reset asserted mid-operation: all in-flight beats are discarded immediately. Outputs return to reset values asynchronously.
- in_max_shift=0: out_data equals the operand. in_max_shift >= A_WIDTH: the shift is limited only by the count.

## Configuration
- NV_DW_LSD_NORM_SHIFT_EN defined: the S2 barrel shifter is built and out_data carries the normalised operand as described.
- NV_DW_LSD_NORM_SHIFT_EN undefined: the shifter is removed and out_data carries the unshifted operand.
  - in_max_shift is ignored.
  - The count, flag, handshake and 2-cycle latency are unchanged.

## Test plan
All cases use A_WIDTH=8 with the shifter enabled unless noted.
- Mode 0, in_data=0xE5, max_shift=8 -> out_enc=2, out_data=0x94, out_all_same=0, out_pvld two edges after accept.
- Mode 1, 0x16 -> enc=3, data=0xB0. Mode 1, 0x00 -> enc=8, data=0x00, all_same=1. Mode 0, 0xFF -> enc=7, data=0x80, all_same=1.
- Clamp: mode 1, 0x05, max_shift=1 -> enc=5, data=0x0A. Repeat with the macro undefined -> data=0x05, enc=5.
- Backpressure: out_prdy=0 for 5 cycles while in_pvld=1 with 0x01,0x02,0x03 -> exactly two beats accepted, then in_prdy=0; on release they emerge in order 0x01,0x02,0x03 with stable fields while stalled.
- Streaming: 100 random beats with random mode/max_shift and out_prdy=1 -> one output per cycle, all matching the reference model.
- Reset: assert nvdla_core_rstn low with two beats in flight -> out_pvld=0 immediately, no stale beat after release, next input handled normally.
